// File: rtl/cdc_capture_arbiter.sv
// rtl/cdc_capture_arbiter.sv - round-robin sequencer for a shared sync-gated CDC capture path
module cdc_capture_arbiter #(
    parameter int NREQ    = 4,
    parameter int HOLDOFF = 2,
    parameter int TIMEOUT = 15
) (
    input  logic            Bclk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            sync,
    output logic [NREQ-1:0] grant,
    output logic            capture,
    output logic [NREQ-1:0] done,
    output logic            timeout,
    output logic            busy
);

    localparam int IW          = $clog2(NREQ);
    localparam int HW          = 4;
    localparam int WW          = 8;
    localparam int HOLD_LAST_I = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam int WAIT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LAST_I);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LAST_I);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_HOLDOFF   = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [NREQ-1:0] grant_nx;
    logic [NREQ-1:0] done_nx;
    logic            timeout_nx;
    logic [IW-1:0]   win, win_nx;
    logic [IW-1:0]   rr_ptr, rr_nx;
    logic [WW-1:0]   wait_cnt, wait_nx;
    logic [HW-1:0]   hold_cnt, hold_nx;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand_idx;
    logic [IW-1:0]   win_next_ptr;
    int              cand;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign win_next_ptr = (win == LAST_REQ) ? '0 : win + IW'(1);

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        done_nx    = '0;
        timeout_nx = 1'b0;
        win_nx     = win;
        rr_nx      = rr_ptr;
        wait_nx    = wait_cnt;
        hold_nx    = hold_cnt;
        capture    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nx           = ST_WAIT_SYNC;
                    grant_nx           = '0;
                    grant_nx[pick_idx] = 1'b1;
                    win_nx             = pick_idx;
                    wait_nx            = '0;
                end
            end

            ST_WAIT_SYNC: begin
                // A withdrawn request abandons the slot even if sync arrives the same cycle.
                if (!req[win]) begin
                    state_nx = ST_IDLE;
                    grant_nx = '0;
                    rr_nx    = win_next_ptr;
                end else if (sync || (wait_cnt == WAIT_LAST)) begin
                    if (sync) begin
                        capture      = 1'b1;
                        done_nx[win] = 1'b1;
                    end else begin
                        timeout_nx = 1'b1;
                    end
                    grant_nx = '0;
                    rr_nx    = win_next_ptr;
                    hold_nx  = '0;
                    state_nx = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end else if (wait_cnt != '1) begin
                    wait_nx = wait_cnt + WW'(1);
                end
            end

            ST_HOLDOFF: begin
                grant_nx = '0;
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    hold_nx = hold_cnt + HW'(1);
                end
            end

            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge Bclk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            done     <= '0;
            timeout  <= 1'b0;
            win      <= '0;
            rr_ptr   <= '0;
            wait_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            done     <= done_nx;
            timeout  <= timeout_nx;
            win      <= win_nx;
            rr_ptr   <= rr_nx;
            wait_cnt <= wait_nx;
            hold_cnt <= hold_nx;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cdc_capture_arbiter.sv
// tb/tb_cdc_capture_arbiter.sv - randomized bench for cdc_capture_arbiter against a cycle-level reference model
module tb_cdc_capture_arbiter;

    localparam int NREQ    = 4;
    localparam int HOLDOFF = 2;
    localparam int TIMEOUT = 15;

    logic            Bclk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic            sync = 1'b0;
    logic [NREQ-1:0] grant;
    logic            capture;
    logic [NREQ-1:0] done;
    logic            timeout;
    logic            busy;

    cdc_capture_arbiter #(
        .NREQ    (NREQ),
        .HOLDOFF (HOLDOFF),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Bclk    (Bclk),
        .reset   (reset),
        .req     (req),
        .sync    (sync),
        .grant   (grant),
        .capture (capture),
        .done    (done),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 Bclk = ~Bclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the path, how long it has owned it, idle gap left.
    int m_owner;
    int m_age;
    int m_gap;
    int m_ptr;
    int m_pend_done;
    bit m_pend_to;

    logic [NREQ-1:0] prev_grant;
    logic            obs_capture;
    logic            obs_timeout;
    int              grant_log[$];

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_owner     = -1;
        m_age       = 0;
        m_gap       = 0;
        m_ptr       = 0;
        m_pend_done = -1;
        m_pend_to   = 1'b0;
        prev_grant  = '0;
    endtask

    task automatic model_step();
        int cidx;
        m_pend_done = -1;
        m_pend_to   = 1'b0;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_gap   = 0;
            end else if (sync) begin
                m_pend_done = m_owner;
                m_ptr       = (m_owner + 1) % NREQ;
                m_owner     = -1;
                m_gap       = HOLDOFF;
            end else if (m_age == TIMEOUT - 1) begin
                m_pend_to = 1'b1;
                m_ptr     = (m_owner + 1) % NREQ;
                m_owner   = -1;
                m_gap     = HOLDOFF;
            end else begin
                m_age++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cidx = (m_ptr + k) % NREQ;
                if (m_owner < 0 && req[cidx]) begin
                    m_owner = cidx;
                    m_age   = 0;
                end
            end
        end
    endtask

    // Called at posedge+1; compares this cycle's outputs at negedge, then advances the model.
    task automatic run_cycle();
        logic [NREQ-1:0] e_grant;
        logic [NREQ-1:0] e_done;
        logic            e_cap;
        @(negedge Bclk);
        e_grant = (m_owner >= 0) ? onehot(m_owner) : '0;
        e_done  = (m_pend_done >= 0) ? onehot(m_pend_done) : '0;
        e_cap   = (m_owner >= 0) && sync && req[m_owner];
        check_eq("grant", 32'(grant), 32'(e_grant));
        check_eq("capture", 32'(capture), 32'(e_cap));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("timeout", 32'(timeout), 32'(m_pend_to));
        check_eq("busy", 32'(busy), 32'((m_owner >= 0) || (m_gap > 0)));
        if (grant != '0 && prev_grant == '0) grant_log.push_back(idx_of(grant));
        prev_grant  = grant;
        obs_capture = capture;
        obs_timeout = timeout;
        @(posedge Bclk);
        model_step();
        #1;
    endtask

    task automatic tick(input logic [NREQ-1:0] r, input logic s);
        req  = r;
        sync = s;
        run_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        sync  = 1'b0;
        @(negedge Bclk);
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_capture", 32'(capture), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_timeout", 32'(timeout), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        @(posedge Bclk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int              found;
        int              sync_pct;
        logic            cap_seen;
        logic [NREQ-1:0] r;

        model_reset();
        obs_capture = 1'b0;
        obs_timeout = 1'b0;
        @(posedge Bclk);
        #1;
        do_reset();

        // Reset asserted mid-WAIT_SYNC clears outputs with no clock edge
        tick(4'b0010, 1'b0);
        check_eq("t5_grant_before", 32'(grant), 32'h2);
        tick(4'b0010, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_async_grant", 32'(grant), 32'h0);
        check_eq("t5_async_capture", 32'(capture), 32'h0);
        check_eq("t5_async_done", 32'(done), 32'h0);
        check_eq("t5_async_timeout", 32'(timeout), 32'h0);
        check_eq("t5_async_busy", 32'(busy), 32'h0);
        @(posedge Bclk);
        #1;
        reset = 1'b0;
        model_reset();
        tick(4'b1111, 1'b0);
        check_eq("t5_first_arb", 32'(grant), 32'h1);
        tick(4'b0000, 1'b0);
        repeat (3) tick(4'b0000, 1'b0);

        // Single requester, sync three cycles after grant
        tick(4'b0100, 1'b0);
        check_eq("t1_grant", 32'(grant), 32'h4);
        repeat (3) tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b1);
        check_eq("t1_capture", 32'(obs_capture), 32'h1);
        check_eq("t1_done", 32'(done), 32'h4);

        // sync during HOLDOFF and IDLE with no request never captures
        cap_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(4'b0000, 1'b1);
            cap_seen = cap_seen | obs_capture;
        end
        check_eq("t6_no_capture", 32'(cap_seen), 32'h0);

        // All requesters held, sync every 4 cycles: strict rotation from 0
        do_reset();
        grant_log.delete();
        for (int c = 0; c < 60; c++) tick(4'b1111, (c % 4) == 3);
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_order", 32'((grant_log.size() > i) ? grant_log[i] : -1), 32'(i % NREQ));
        end

        // No sync: timeout, then rotation to requester 2
        do_reset();
        grant_log.delete();
        found = -1;
        tick(4'b0110, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            if (grant_log.size() < 2) begin
                tick(4'b0110, 1'b0);
                if (obs_timeout && found < 0) found = k;
            end
        end
        check_eq("t3_timeout_cycle", 32'(found), 32'(TIMEOUT + 1));
        check_eq("t3_first_grant", 32'((grant_log.size() > 0) ? grant_log[0] : -1), 32'h1);
        check_eq("t3_next_grant", 32'((grant_log.size() > 1) ? grant_log[1] : -1), 32'h2);

        // Granted requester withdraws in the same cycle as sync
        tick(4'b0000, 1'b1);
        check_eq("t4_no_capture", 32'(obs_capture), 32'h0);
        check_eq("t4_idle_busy", 32'(busy), 32'h0);
        tick(4'b1001, 1'b0);
        check_eq("t4_ptr_advanced", 32'(grant), 32'h8);

        // Randomized traffic against the model
        r        = 4'b1001;
        sync_pct = 20;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(2))
                    0: sync_pct = 0;
                    1: sync_pct = 6;
                    default: sync_pct = 35;
                endcase
            end
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            tick(r, ($urandom_range(99) < sync_pct));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
